// File: rtl/ps2_device_tx.sv
// ---------------------------------------------------------------------------
// ps2_device_tx
//
// Device-side (mouse end) PS/2 transmitter. Takes one byte at a time over a
// valid/ready handshake, generates the PS/2 clock itself and shifts the byte
// out as an 11-bit frame {stop=1, odd parity, data[7:0], start=0}, LSB first,
// on open-drain clock/data lines (the *_oe outputs pull the line low).
//
// Parameters:
//   CLK_HALF      clk_sys cycles per PS/2 clock half-period
//   DATA_SETUP    cycles data is stable before each falling clock edge
//                 (must be less than CLK_HALF)
//   IDLE_HOLDOFF  cycles both lines must read high before a frame starts
//
// Ports:
//   clk_sys      in   system clock
//   rst_n        in   asynchronous active-low reset
//   tx_data      in   byte to send
//   tx_valid     in   tx_data is valid
//   tx_ready     out  block can accept a byte
//   ps2_clk_i    in   PS/2 clock line sense (asynchronous)
//   ps2_clk_oe   out  1 = pull PS/2 clock low
//   ps2_data_i   in   PS/2 data line sense (asynchronous)
//   ps2_data_oe  out  1 = pull PS/2 data low
//   busy         out  frame in progress or pending
//   tx_done      out  one-cycle pulse when a frame completes
//   tx_abort     out  one-cycle pulse when the host inhibits a frame
//
// Build option:
//   PS2_DEV_INHIBIT_RETRY_EN  defined: an inhibited frame is kept and resent
//                             in full once the bus is idle again (unlimited
//                             retries). Undefined: the byte is dropped.
//
// Handshake: a byte transfers on any clk_sys rising edge where tx_valid and
// tx_ready are both 1; tx_ready stays 0 from the following cycle until the
// frame has finished (or been dropped), so tx_data need only be held while
// tx_valid is high and not yet accepted.
// ---------------------------------------------------------------------------
module ps2_device_tx #(
   parameter int CLK_HALF     = 2000,
   parameter int DATA_SETUP   = 250,
   parameter int IDLE_HOLDOFF = 2500
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   output logic       ps2_clk_oe,
   input  logic       ps2_data_i,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_abort
);

   localparam int MAX_CNT = (CLK_HALF > IDLE_HOLDOFF) ? CLK_HALF : IDLE_HOLDOFF;
   localparam int CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(IDLE_HOLDOFF - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(DATA_SETUP - 1);
   localparam logic [CW-1:0] LOW_LAST   = CW'(CLK_HALF - 1);
   localparam logic [CW-1:0] HIGH_LAST  = CW'(CLK_HALF - DATA_SETUP - 1);
   // The released clock needs a few cycles to rise and pass the synchronizer
   // before a low reading can be trusted as a host inhibit.
   localparam logic [2:0]    MASK_CYC   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BUS,
      S_SETUP,
      S_LOW,
      S_HIGH,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [1:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    rel_cnt_q;   // cycles since the clock was last released
   logic [3:0]    idx_q;       // frame bit currently on the line
   logic [10:0]   frame_q;
   logic          tx_ready_q;
   logic          busy_q;
   logic          clk_oe_q;
   logic          data_oe_q;
   logic          done_q;
   logic          abort_q;

   logic          clk_s;
   logic          data_s;
   logic [3:0]    idx_d;
   logic          inhibit;

   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];
   assign idx_d  = idx_q + 4'd1;

   // Host pulling the clock low while we release it. Bit 10 (stop) is past
   // the point of no return, so an inhibit there is ignored.
   assign inhibit = ((state_q == S_SETUP) || (state_q == S_HIGH)) &&
                    (rel_cnt_q == MASK_CYC) && !clk_s && (idx_q <= 4'd9);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rel_cnt_q   <= '0;
         idx_q       <= '0;
         frame_q     <= '1;
         tx_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         done_q      <= 1'b0;
         abort_q     <= 1'b0;

         if (((state_q == S_SETUP) || (state_q == S_HIGH)) && (rel_cnt_q != MASK_CYC))
            rel_cnt_q <= rel_cnt_q + 3'd1;

         if (inhibit) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            abort_q   <= 1'b1;
            cnt_q     <= '0;
`ifdef PS2_DEV_INHIBIT_RETRY_EN
            state_q   <= S_WAIT_BUS;
`else
            state_q    <= S_IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (tx_valid && tx_ready_q) begin
                     frame_q    <= {1'b1, ~^tx_data, tx_data, 1'b0};
                     tx_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                     cnt_q      <= '0;
                     state_q    <= S_WAIT_BUS;
                  end
               end
               S_WAIT_BUS: begin
                  // Any low on either line (inhibit or request-to-send)
                  // restarts the idle count.
                  if (clk_s && data_s) begin
                     if (cnt_q == HOLD_LAST) begin
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        rel_cnt_q <= '0;
                        data_oe_q <= ~frame_q[0];
                        state_q   <= S_SETUP;
                     end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                     end
                  end else begin
                     cnt_q <= '0;
                  end
               end
               S_SETUP: begin
                  if (cnt_q == SETUP_LAST) begin
                     cnt_q    <= '0;
                     clk_oe_q <= 1'b1;
                     state_q  <= S_LOW;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_LOW: begin
                  if (cnt_q == LOW_LAST) begin
                     cnt_q     <= '0;
                     clk_oe_q  <= 1'b0;
                     rel_cnt_q <= '0;
                     state_q   <= S_HIGH;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_HIGH: begin
                  if (cnt_q == HIGH_LAST) begin
                     cnt_q <= '0;
                     if (idx_q == 4'd10) begin
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                     end else begin
                        idx_q     <= idx_d;
                        data_oe_q <= ~frame_q[idx_d];
                        state_q   <= S_SETUP;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_DONE: begin
                  clk_oe_q   <= 1'b0;
                  data_oe_q  <= 1'b0;
                  tx_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign tx_ready    = tx_ready_q;
   assign busy        = busy_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_done     = done_q;
   assign tx_abort    = abort_q;

endmodule
